// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU issue types, op codes, flag positions and control-word fields
package fpu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} fpu_state_t;
  localparam logic [3:0] FPU_OP_FSUB    = 4'd0;
  localparam logic [3:0] FPU_OP_FADD    = 4'd1;
  localparam logic [3:0] FPU_OP_FMUL    = 4'd2;
  localparam logic [3:0] FPU_OP_FDIV    = 4'd3;
  localparam logic [3:0] FPU_OP_FSGNJ   = 4'd4;
  localparam logic [3:0] FPU_OP_FMINMAX = 4'd5;
  localparam logic [3:0] FPU_OP_FSQRT   = 4'd6;
  localparam logic [3:0] FPU_OP_FCMP    = 4'd7;
  localparam logic [3:0] FPU_OP_FCVT_WS = 4'd8;
  localparam logic [3:0] FPU_OP_FCVT_SW = 4'd9;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam int CW_FPU_SEL = 18;
  localparam int CW_OP_HI   = 19;
  localparam int CW_OP_MSB  = 10;
  localparam int CW_OP_LSB  = 8;
  function automatic logic [3:0] cw_op(input logic [19:0] cw);
    return {cw[CW_OP_HI], cw[CW_OP_MSB:CW_OP_LSB]};
  endfunction
endpackage

// File: rtl/fpu_watchdog.sv
// fpu_watchdog: counts outstanding-op cycles and flags the last allowed one
module fpu_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt;
  assign expire = en & (cnt == CNT_W'(TIMEOUT - 1));
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: EX-stage sequencer that issues one FPU op, stalls until done and accrues fflags
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [19:0] ex_signals,
  input  logic        ex_flush,
  input  logic [31:0] ex_op_a,
  input  logic [31:0] ex_op_b,
  input  logic        fflags_clr,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        fpu_start,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  fflags,
  output logic        timeout
);
  localparam logic [4:0] TMO_FLAGS = 5'(1) << FLAG_NV;
  fpu_state_t state;
  logic go, done_ok, expire, unused_cw;
  logic [4:0] res_flags;
  assign unused_cw = ^{ex_signals[17:11], ex_signals[7:0]};
  assign go = ex_valid & ex_signals[CW_FPU_SEL] & ~ex_flush;
  // a done pulse in the launch cycle cannot belong to this op
  assign done_ok = fpu_done & ~fpu_start;
  assign stall = (state == IDLE) ? go : (state != DONE);
  fpu_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == IDLE),
    .en     (state == BUSY || state == DRAIN),
    .expire (expire)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      fpu_start <= 1'b0;
      fpu_op    <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      wb_valid  <= 1'b0;
      wb_result <= '0;
      res_flags <= '0;
      fflags    <= '0;
      timeout   <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      wb_valid  <= 1'b0;
      timeout   <= 1'b0;
      fflags    <= (fflags_clr ? 5'b0 : fflags) | ((state == DONE) ? res_flags : 5'b0);
      case (state)
        IDLE:
          if (go) begin
            state     <= BUSY;
            fpu_start <= 1'b1;
            fpu_op    <= cw_op(ex_signals);
            fpu_a     <= ex_op_a;
            fpu_b     <= ex_op_b;
          end
        BUSY:
          if (ex_flush) state <= done_ok ? IDLE : DRAIN;
          else if (done_ok) begin
            state     <= DONE;
            wb_valid  <= 1'b1;
            wb_result <= fpu_result;
            res_flags <= fpu_flags;
          end else if (expire) begin
            state     <= DONE;
            wb_valid  <= 1'b1;
            timeout   <= 1'b1;
            wb_result <= '0;
            res_flags <= TMO_FLAGS;
          end
        DRAIN: if (fpu_done || expire) state <= IDLE;
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Execute-stage sequencer for the multicycle FPU. It consumes the 20-bit decoded control word produced by `controlUnit` (after the ID/EX register) and identifies FPU-routed instructions. For each one it launches a single FPU operation, stalls the pipeline until the result returns, and presents the result for writeback. It also maintains the sticky `fflags` accrued-exception register.

## Interface

Parameters:
- `TIMEOUT`, default 64: maximum number of BUSY cycles to wait for `fpu_done` before aborting.
- `CNT_W`, default `$clog2(TIMEOUT+1)`: watchdog counter width.

Ports (reset is synchronous and active-low; one clock):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `ex_valid` input 1: a valid instruction is in EX.
- `ex_signals` input 20: control word from `controlUnit`.
- `ex_flush` input 1: kill the instruction in EX (branch/jump redirect).
- `ex_op_a`, `ex_op_b` input 32: operand values from the EX operand muxes.
- `fflags_clr` input 1: CSR write clears `fflags`.
- `fpu_done` input 1: one-cycle pulse from the FPU; result and flags valid.
- `fpu_result` input 32: FPU result.
- `fpu_flags` input 5: NV, DZ, OF, UF, NX.
- `fpu_start` output 1: one-cycle launch pulse.
- `fpu_op` output 4: FPU operation code.
- `fpu_a`, `fpu_b` output 32: registered FPU operands.
- `stall` output 1: freeze IF/ID/EX.
- `wb_valid` output 1: result available this cycle.
- `wb_result` output 32: result for writeback.
- `fflags` output 5: sticky accrued exceptions.
- `timeout` output 1: one-cycle pulse on watchdog expiry.

## Operation

- `is_fpu = ex_valid & ex_signals[18]`.
- Operation code: `op = {ex_signals[19], ex_signals[10:8]}`, giving values 0–9. Any code above 9 is still issued; the FPU defines the result.
- FSM states are IDLE, BUSY, DONE and DRAIN.
- **IDLE**
  - If `is_fpu & ~ex_flush`: capture `op`, `ex_op_a` and `ex_op_b` into `fpu_op`, `fpu_a` and `fpu_b`; clear the watchdog counter; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `fpu_start` is 1 only in the first BUSY cycle, which is registered. `fpu_done` is ignored in that cycle.
  - The watchdog counter increments every BUSY cycle.
  - If `fpu_done` arrives (in a later cycle): capture `fpu_result` and `fpu_flags`; go to DONE.
  - If `ex_flush` is asserted and `fpu_done` is absent: go to DRAIN. Flush and done in the same cycle: flush wins; go to IDLE and discard the result.
  - If the counter reaches `TIMEOUT`: pulse `timeout`; load result `32'h0` and flags `5'b10000`; go to DONE.
- **DONE**
  - `wb_valid=1`; `wb_result` holds the captured value.
  - Captured flags are ORed into `fflags`.
  - Always go to IDLE next.
- **DRAIN**
  - Discard the next `fpu_done` pulse, then go to IDLE.
  - The watchdog continues counting. Expiry goes to IDLE with no `timeout` pulse.
- `stall` is combinational:
  - IDLE: `is_fpu & ~ex_flush`.
  - BUSY: 1.
  - DRAIN: 1.
  - DONE: 0.
- `fflags` update rule:
  - `fflags_clr` alone sets `fflags` to 0.
  - If DONE coincides with `fflags_clr`, `fflags` becomes exactly the new flags (clear first, then accrue).
  - Otherwise `fflags` is ORed with the new flags.
- Non-FPU instructions never stall and never touch `fflags`.

## Timing

- Reset values: state IDLE; `fpu_start`, `wb_valid`, `timeout`, `stall` = 0; `fpu_op` = 0; `fpu_a`, `fpu_b`, `wb_result` = 0; `fflags` = 0; counter 0.
- Reset mid-operation returns to IDLE on the next edge. A late `fpu_done` arriving afterwards is ignored, because IDLE never samples it.
- Latency: an FPU op that takes L≥1 cycles after `fpu_start` gives:
  - detect in cycle 0;
  - `fpu_start` in cycle 1;
  - `fpu_done` in cycle 1+L;
  - `wb_valid` in cycle 2+L.
- `stall` is high in cycles 0 through 1+L and drops in the DONE cycle, so EX advances at the end of DONE.
- Back-to-back FPU instructions: the second is detected in the IDLE cycle that follows DONE. Minimum spacing is L+3 cycles.
- `ex_op_a` and `ex_op_b` only need to be stable in the detect cycle. The block registers them.

## Structure

- Shared package `fpu_pkg`:
  - FSM state enum.
  - `FPU_OP_*` codes 0–9: FSUB 0, FADD 1, FMUL 2, FDIV 3, FSGNJ 4, FMINMAX 5, FSQRT 6, FCMP 7, FCVT_WS 8, FCVT_SW 9.
  - Flag bit positions.
  - Control-word bit indices 18 (FPU select), 19 and 10:8 (op code).
- One natural sub-module: `fpu_watchdog`, holding the counter, clear/enable logic and expiry pulse.

## Test plan

1. Reset → all outputs 0 and state IDLE. Then drive FADD (`ex_signals=20'h78100`) with a=3F800000, b=40000000, and FPU done L=3 with result 40400000 → `fpu_start` in cycle 1 with `fpu_op=1`; `stall` high in cycles 0–4; `wb_valid` with `wb_result=40400000` in cycle 5.
2. Two consecutive FMUL ops (`ex_signals=20'h78200`), L=1, flags `5'b00001` then `5'b00100` → starts in cycles 1 and 5 (op 2); `fflags=5'b00101` after the second DONE.
3. `ex_flush` in the second BUSY cycle, FPU done 4 cycles later → no `wb_valid`; `stall` high until the cycle after `fpu_done`; `fflags` unchanged; the next FADD issues normally.
4. `TIMEOUT=8`, `fpu_done` never asserted → one `timeout` pulse after the 8th BUSY cycle; `wb_result=0`; `fflags[4]=1`.
5. DONE with flags `5'b00010` while `fflags=5'b10000` and `fflags_clr=1` → `fflags=5'b00010`.
6. Non-FPU instruction (`ex_signals=20'h00210`, R-type) → `stall=0`, `fpu_start=0`, `fflags` unchanged. Also: `rst_n` low mid-BUSY followed by a late `fpu_done` → no `wb_valid`, state IDLE.
